// File: rtl/hh_tdm_core.sv
// Time-multiplexed Hodgkin-Huxley neuron array. Each sweep advances every neuron
// by one explicit-Euler step. All neurons share one signed fixed-point multiplier:
// per neuron the sequence is LOAD, 16 multiplies, then WRITE (18 cycles).
module hh_tdm_core #(
  parameter int W           = 16,
  parameter int F           = 7,
  parameter int NUM_NEURONS = 4,
  parameter int DT_SHIFT    = 5,
  parameter int G_NA        = 15360,
  parameter int G_K         = 4608,
  parameter int G_L         = 38,
  parameter int E_NA        = 6400,
  parameter int E_K         = -9856,
  parameter int E_L         = -6962,
  parameter int V_REST      = -8320,
  parameter int N_INIT      = 41,
  parameter int M_INIT      = 7,
  parameter int H_INIT      = 76,
  parameter int V_TH        = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_NEURONS*W-1:0] current_in,
  input  logic [W-1:0]             alpha_n,
  input  logic [W-1:0]             beta_n,
  input  logic [W-1:0]             alpha_m,
  input  logic [W-1:0]             beta_m,
  input  logic [W-1:0]             alpha_h,
  input  logic [W-1:0]             beta_h,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_NEURONS*W-1:0] v_out,
  output logic [NUM_NEURONS-1:0]   spike
);
  localparam int IDXW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  typedef logic signed [W-1:0] sw_t;

  localparam logic signed [2*W-1:0] SMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] SMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  localparam sw_t C_ONE = sw_t'(1 << F);
  localparam sw_t C_GNA = sw_t'(G_NA);
  localparam sw_t C_GK  = sw_t'(G_K);
  localparam sw_t C_GL  = sw_t'(G_L);
  localparam sw_t C_ENA = sw_t'(E_NA);
  localparam sw_t C_EK  = sw_t'(E_K);
  localparam sw_t C_EL  = sw_t'(E_L);
  localparam sw_t C_VTH = sw_t'(V_TH);

  typedef enum logic [4:0] {
    S_IDLE, S_LOAD,
    S_MUL0, S_MUL1, S_MUL2, S_MUL3, S_MUL4, S_MUL5, S_MUL6, S_MUL7,
    S_MUL8, S_MUL9, S_MUL10, S_MUL11, S_MUL12, S_MUL13, S_MUL14, S_MUL15,
    S_WRITE, S_DONE
  } state_t;

  function automatic sw_t f_sat(input logic signed [2*W-1:0] x);
    if (x > SMAX)      f_sat = {1'b0, {(W-1){1'b1}}};
    else if (x < SMIN) f_sat = {1'b1, {(W-1){1'b0}}};
    else               f_sat = x[W-1:0];
  endfunction

  function automatic sw_t f_add(input sw_t a, input sw_t b);
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    f_add = f_sat({{(W-1){s[W]}}, s});
  endfunction

  function automatic sw_t f_sub(input sw_t a, input sw_t b);
    logic signed [W:0] s;
    s = {a[W-1], a} - {b[W-1], b};
    f_sub = f_sat({{(W-1){s[W]}}, s});
  endfunction

  // Full-width product, floor-shift by F, saturate back to W bits.
  function automatic sw_t f_mul(input sw_t a, input sw_t b);
    logic signed [2*W-1:0] p;
    p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    p = p >>> F;
    f_mul = f_sat(p);
  endfunction

  function automatic sw_t f_clamp(input sw_t x);
    if (x < 0)          f_clamp = '0;
    else if (x > C_ONE) f_clamp = C_ONE;
    else                f_clamp = x;
  endfunction

  state_t r_state;
  logic [IDXW-1:0] r_idx;
  logic r_busy, r_done;
  logic [NUM_NEURONS-1:0] r_spike;
  logic [NUM_NEURONS-1:0][W-1:0] r_v, r_n, r_m, r_h;
  sw_t r_vw, r_nw, r_mw, r_hw, r_iw;
  sw_t r_t1, r_t2, r_ina, r_ik, r_il;
  sw_t r_pan, r_pbn, r_pam, r_pbm, r_pah, r_pbh;
  sw_t r_an, r_bn, r_am, r_bm, r_ah, r_bh;

  logic [NUM_NEURONS-1:0][W-1:0] w_cur;
  sw_t w_a, w_b, w_prod;
  sw_t w_i3, w_vnew, w_nnew, w_mnew, w_hnew;

  assign w_cur = current_in;
  assign busy  = r_busy;
  assign done  = r_done;
  assign v_out = r_v;
  assign spike = r_spike;

  // Operand select for the shared multiplier, one product per MUL state.
  always_comb begin
    w_a = '0;
    w_b = '0;
    case (r_state)
      S_MUL0:  begin w_a = r_mw;  w_b = r_mw;                  end
      S_MUL1:  begin w_a = r_t1;  w_b = r_mw;                  end
      S_MUL2:  begin w_a = r_t1;  w_b = r_hw;                  end
      S_MUL3:  begin w_a = C_GNA; w_b = r_t1;                  end
      S_MUL4:  begin w_a = r_nw;  w_b = r_nw;                  end
      S_MUL5:  begin w_a = r_t2;  w_b = r_t2;                  end
      S_MUL6:  begin w_a = C_GK;  w_b = r_t2;                  end
      S_MUL7:  begin w_a = r_t1;  w_b = f_sub(r_vw, C_ENA);    end
      S_MUL8:  begin w_a = r_t2;  w_b = f_sub(r_vw, C_EK);     end
      S_MUL9:  begin w_a = C_GL;  w_b = f_sub(r_vw, C_EL);     end
      S_MUL10: begin w_a = r_an;  w_b = f_sub(C_ONE, r_nw);    end
      S_MUL11: begin w_a = r_bn;  w_b = r_nw;                  end
      S_MUL12: begin w_a = r_am;  w_b = f_sub(C_ONE, r_mw);    end
      S_MUL13: begin w_a = r_bm;  w_b = r_mw;                  end
      S_MUL14: begin w_a = r_ah;  w_b = f_sub(C_ONE, r_hw);    end
      S_MUL15: begin w_a = r_bh;  w_b = r_hw;                  end
      default: ;
    endcase
    w_prod = f_mul(w_a, w_b);
  end

  // Euler update of the working neuron, consumed in WRITE.
  always_comb begin
    w_i3   = f_sub(f_sub(f_sub(r_iw, r_ina), r_ik), r_il);
    w_vnew = f_add(r_vw, w_i3 >>> DT_SHIFT);
    w_nnew = f_clamp(f_add(r_nw, f_sub(r_pan, r_pbn) >>> DT_SHIFT));
    w_mnew = f_clamp(f_add(r_mw, f_sub(r_pam, r_pbm) >>> DT_SHIFT));
    w_hnew = f_clamp(f_add(r_hw, f_sub(r_pah, r_pbh) >>> DT_SHIFT));
  end

  // Sweep sequencer, per-neuron state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_spike <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_v[i] <= sw_t'(V_REST);
        r_n[i] <= sw_t'(N_INIT);
        r_m[i] <= sw_t'(M_INIT);
        r_h[i] <= sw_t'(H_INIT);
      end
      {r_vw, r_nw, r_mw, r_hw, r_iw} <= '0;
      {r_t1, r_t2, r_ina, r_ik, r_il} <= '0;
      {r_pan, r_pbn, r_pam, r_pbm, r_pah, r_pbh} <= '0;
      {r_an, r_bn, r_am, r_bm, r_ah, r_bh} <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_an <= alpha_n; r_bn <= beta_n;
          r_am <= alpha_m; r_bm <= beta_m;
          r_ah <= alpha_h; r_bh <= beta_h;
          r_idx   <= '0;
          r_busy  <= 1'b1;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_vw <= r_v[r_idx];
          r_nw <= r_n[r_idx];
          r_mw <= r_m[r_idx];
          r_hw <= r_h[r_idx];
          r_iw <= w_cur[r_idx];
          r_state <= S_MUL0;
        end
        S_WRITE: begin
          r_v[r_idx]     <= w_vnew;
          r_n[r_idx]     <= w_nnew;
          r_m[r_idx]     <= w_mnew;
          r_h[r_idx]     <= w_hnew;
          r_spike[r_idx] <= (r_vw < C_VTH) && (w_vnew >= C_VTH);
          if (r_idx == IDXW'(NUM_NEURONS - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx   <= IDXW'(r_idx + 1'b1);
            r_state <= S_LOAD;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          // MUL0..MUL15: store the product, then step to the next state.
          case (r_state)
            S_MUL0, S_MUL1, S_MUL2, S_MUL3: r_t1 <= w_prod;
            S_MUL4, S_MUL5, S_MUL6:         r_t2 <= w_prod;
            S_MUL7:  r_ina <= w_prod;
            S_MUL8:  r_ik  <= w_prod;
            S_MUL9:  r_il  <= w_prod;
            S_MUL10: r_pan <= w_prod;
            S_MUL11: r_pbn <= w_prod;
            S_MUL12: r_pam <= w_prod;
            S_MUL13: r_pbm <= w_prod;
            S_MUL14: r_pah <= w_prod;
            S_MUL15: r_pbh <= w_prod;
            default: ;
          endcase
          r_state <= state_t'(r_state + 5'd1);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hh_tdm_core.sv
// Directed bench for hh_tdm_core: instance u_a uses default conductances
// (timing, reset), instance u_b has all conductances zero so the voltage is
// a pure integrator of current_in and can be hand-computed.
module tb_hh_tdm_core;
  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_a, start_b;
  logic [N*W-1:0] cur;
  logic [W-1:0] an, bn, am, bm, ah, bh;
  logic busy_a, done_a, busy_b, done_b;
  logic [N*W-1:0] vout_a, vout_b;
  logic [N-1:0] spike_a, spike_b;

  int tests = 0;
  int fails = 0;

  hh_tdm_core u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .current_in(cur),
    .alpha_n(an), .beta_n(bn), .alpha_m(am), .beta_m(bm),
    .alpha_h(ah), .beta_h(bh),
    .busy(busy_a), .done(done_a), .v_out(vout_a), .spike(spike_a)
  );

  hh_tdm_core #(.G_NA(0), .G_K(0), .G_L(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .current_in(cur),
    .alpha_n(an), .beta_n(bn), .alpha_m(am), .beta_m(bm),
    .alpha_h(ah), .beta_h(bh),
    .busy(busy_b), .done(done_b), .v_out(vout_b), .spike(spike_b)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [W-1:0] vs(input logic [N*W-1:0] vec, input int i);
    return $signed(vec[i*W +: W]);
  endfunction

  // One sweep on u_b; latency counted from start-sample cycle to done.
  task automatic sweep_b(output int lat);
    lat = 0;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (done_b) begin lat = k; break; end
      @(posedge clk); #1;
    end
    chk("sweep_b_done", (lat != 0), 1);
  endtask

  int firstbusy, lastbusy, busycnt, donecnt, donecyc, lat;

  initial begin
    rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1;
    cur = '0; {an, bn, am, bm, ah, bh} = '0;

    // Reset for two cycles, with start held high (must be ignored).
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) chk("rst_v_a", vs(vout_a, i), -8320);
    chk("rst_spike", spike_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_busy_b", busy_b, 0);

    // Latency with defaults; extra start in cycle 10 must be ignored.
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    firstbusy = 0; lastbusy = 0; busycnt = 0; donecnt = 0; donecyc = 0;
    for (int k = 1; k <= 180; k++) begin
      if (busy_a) begin
        busycnt++;
        lastbusy = k;
        if (firstbusy == 0) firstbusy = k;
      end
      if (done_a) begin
        donecnt++;
        donecyc = k;
        chk("busy_during_done", busy_a, 0);
      end
      if (k == 10) start_a = 1'b1;
      if (k == 11) start_a = 1'b0;
      @(posedge clk); #1;
    end
    chk("first_busy", firstbusy, 1);
    chk("last_busy", lastbusy, 72);
    chk("busy_cycles", busycnt, 72);
    chk("done_cycle", donecyc, 73);
    chk("done_count", donecnt, 1);

    // Mid-sweep reset at cycle 30 on both instances.
    an = 16'd5;
    @(posedge clk); #1 start_a = 1'b1; start_b = 1'b1;
    @(posedge clk); #1 start_a = 1'b0; start_b = 1'b0;
    donecnt = 0;
    for (int k = 1; k <= 180; k++) begin
      if (k == 30) rst_n = 1'b0;
      if (k == 31) begin
        for (int i = 0; i < N; i++) chk("mid_rst_v", vs(vout_a, i), -8320);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_done", done_a, 0);
        chk("mid_rst_spike", spike_a, 0);
        chk("mid_rst_busy_b", busy_b, 0);
        chk("mid_rst_rate", $signed(u_a.r_an), 0);
        rst_n = 1'b1;
      end
      if (done_a || done_b) donecnt++;
      @(posedge clk); #1;
    end
    chk("mid_rst_no_done", donecnt, 0);
    an = '0;

    // Integrator on u_b: currents {n3,n2,n1,n0} = {0, 32767, 0, 4096}.
    cur = {16'd0, 16'd32767, 16'd0, 16'd4096};
    sweep_b(lat);
    chk("lat_after_reset", lat, 73);
    chk("int_v0", vs(vout_b, 0), -8192);
    chk("int_v1", vs(vout_b, 1), -8320);
    chk("int_v2", vs(vout_b, 2), -7297);
    chk("int_v3", vs(vout_b, 3), -8320);
    chk("int_n0", $signed(u_b.r_n[0]), 41);
    for (int s = 2; s <= 8; s++) sweep_b(lat);
    chk("sw8_v2", vs(vout_b, 2), -136);
    chk("sw8_spike2", spike_b[2], 0);
    sweep_b(lat);
    chk("sw9_v2", vs(vout_b, 2), 887);
    chk("sw9_spike2", spike_b[2], 1);
    chk("sw9_v0", vs(vout_b, 0), -7168);
    sweep_b(lat);
    chk("sw10_v2", vs(vout_b, 2), 1910);
    chk("sw10_spike2", spike_b[2], 0);

    // Gating update: alpha_n = 1.0 -> n 41 -> 43, m and h untouched.
    an = 16'd128;
    sweep_b(lat);
    for (int i = 0; i < N; i++) chk("gate_n", $signed(u_b.r_n[i]), 43);
    chk("gate_m0", $signed(u_b.r_m[0]), 7);
    chk("gate_h0", $signed(u_b.r_h[0]), 76);
    chk("sw11_v2", vs(vout_b, 2), 2933);

    // Gating clamp: huge beta_m drives m to 0, not below.
    an = '0; bm = 16'h7FFF;
    sweep_b(lat);
    for (int i = 0; i < N; i++) chk("clamp_m", $signed(u_b.r_m[i]), 0);
    chk("clamp_n0", $signed(u_b.r_n[0]), 43);
    sweep_b(lat);
    chk("clamp_m_hold", $signed(u_b.r_m[1]), 0);
    bm = '0;

    // Saturation: V2 reaches the positive rail at sweep 41 and holds.
    for (int s = 14; s <= 41; s++) sweep_b(lat);
    chk("sat_v2", vs(vout_b, 2), 32767);
    chk("sat_spike2", spike_b[2], 0);
    sweep_b(lat);
    chk("sat_v2_hold", vs(vout_b, 2), 32767);
    chk("sw42_v0", vs(vout_b, 0), -2944);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
